// File: rtl/branch_resolve_unit_if.sv
// Predictor training-update channel between the resolve unit and the IF-stage predictor.
// Latency: none, this is a bundle of wires.
// Backpressure: the predictor holds upd_ready low to stall the head entry in place.
//
// Signals:
//   upd_valid   head entry available (driven by the resolve unit)
//   upd_ready   predictor accepts the head entry this cycle
//   upd_pc      PC of the head entry
//   upd_target  target to install, 0 invalidates the BTB entry
//   upd_taken   outcome used to train the direction counter
interface branch_resolve_unit_if #(
    parameter int PC_W = 16
) ();
    logic            upd_valid;
    logic            upd_ready;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;

    modport master (
        output upd_valid,
        output upd_pc,
        output upd_target,
        output upd_taken,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_pc,
        input  upd_target,
        input  upd_taken,
        output upd_ready
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution: pipes prediction metadata IF->EX/MEM, flags mispredicts, queues training updates.
// Latency: outcome to flush/redirect_pc 0 cycles (combinational); outcome to upd_valid 1 cycle.
// Backpressure: update queue holds entries while upd_ready=0; a push into a full queue without a pop is dropped.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   if_*                           fetch-stage prediction metadata
//   data_stall                     load-use stall (IF/ID holds, bubble into ID/EX)
//   res_*                          actual outcome of the instruction in EX/MEM
//   flush, redirect_pc             mispredict recovery
//   upd (branch_resolve_unit_if)   training-update channel, master side
//   q_count                        update queue occupancy
//   stat_branches/mispredicts/drops  saturating counters, present only with `define BRU_STATS_EN
module branch_resolve_unit #(
    parameter int PC_W   = 16,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        if_valid,
    input  logic [PC_W-1:0]             if_pc,
    input  logic                        if_pred_taken,
    input  logic [PC_W-1:0]             if_pred_target,
    input  logic                        data_stall,
    input  logic                        res_valid,
    input  logic                        res_is_ctrl,
    input  logic                        res_is_cond,
    input  logic                        res_taken,
    input  logic [PC_W-1:0]             res_target,
    output logic                        flush,
    output logic [PC_W-1:0]             redirect_pc,
    branch_resolve_unit_if.master       upd,
    output logic [$clog2(QDEPTH):0]     q_count
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_W-1:0]            stat_branches,
    output logic [CNT_W-1:0]            stat_mispredicts,
    output logic [CNT_W-1:0]            stat_drops
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam int QW = AW + 1;

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
        $error("branch_resolve_unit: QDEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } meta_t;

    meta_t if_meta, if_id, id_ex, ex_mem;

    assign if_meta = '{valid: if_valid, pc: if_pc, pred_taken: if_pred_taken, pred_target: if_pred_target};

    // Flush wins over stall: everything younger than EX/MEM is wrong-path.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
        end else if (flush) begin
            if_id  <= '0;
            id_ex  <= '0;
            ex_mem <= '0;
        end else begin
            if (!data_stall) begin
                if_id <= if_meta;
                id_ex <= if_id;
            end else begin
                id_ex <= '0;
            end
            ex_mem <= id_ex;
        end
    end

    // Resolution
    logic            resolve;
    logic            alias_hit;
    logic            ctrl_miss;
    logic [PC_W-1:0] pc_inc;

    assign resolve   = ex_mem.valid && res_valid;
    // A non-control instruction predicted taken means the BTB entry aliases; it must be invalidated.
    assign alias_hit = resolve && !res_is_ctrl && ex_mem.pred_taken;
    assign ctrl_miss = resolve && res_is_ctrl &&
                       ((ex_mem.pred_taken != res_taken) ||
                        (ex_mem.pred_taken && res_taken && (ex_mem.pred_target != res_target)));
    assign flush       = ctrl_miss || alias_hit;
    assign pc_inc      = ex_mem.pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign redirect_pc = flush ? (res_taken ? res_target : pc_inc) : '0;

    // Update queue
    logic [PC_W-1:0] q_pc  [QDEPTH];
    logic [PC_W-1:0] q_tgt [QDEPTH];
    logic            q_tkn [QDEPTH];
    logic [AW-1:0]   q_head, q_tail;
    logic [QW-1:0]   q_cnt;

    logic            push_req, push_ok, pop, full, drop;
    logic [PC_W-1:0] push_tgt;
    logic            push_tkn;

    assign push_req = resolve && (res_is_ctrl || alias_hit);
    // Not-taken conditionals still report the branch target so the BTB keeps it.
    assign push_tgt = alias_hit ? '0 :
                      ((res_taken || res_is_cond) ? res_target : ex_mem.pred_target);
    assign push_tkn = res_is_ctrl && res_taken;
    assign full     = (q_cnt == QW'(QDEPTH));
    assign pop      = upd.upd_valid && upd.upd_ready;
    // A same-cycle pop frees the slot, so a full queue can still accept.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_head <= '0;
            q_tail <= '0;
            q_cnt  <= '0;
        end else begin
            if (push_ok) q_tail <= q_tail + 1'b1;
            if (pop)     q_head <= q_head + 1'b1;
            case ({push_ok, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_pc[q_tail]  <= ex_mem.pc;
            q_tgt[q_tail] <= push_tgt;
            q_tkn[q_tail] <= push_tkn;
        end
    end

    assign upd.upd_valid  = (q_cnt != '0);
    assign upd.upd_pc     = q_pc[q_head];
    assign upd.upd_target = q_tgt[q_head];
    assign upd.upd_taken  = q_tkn[q_head];
    assign q_count        = q_cnt;

`ifdef BRU_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
            stat_drops       <= '0;
        end else begin
            if (push_ok && stat_branches    != '1) stat_branches    <= stat_branches + 1'b1;
            if (flush   && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
            if (drop    && stat_drops       != '1) stat_drops       <= stat_drops + 1'b1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid, if_pred_taken, data_stall;
    logic [15:0] if_pc, if_pred_target;
    logic        res_valid, res_is_ctrl, res_is_cond, res_taken;
    logic [15:0] res_target;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [2:0]  q_count;
`ifdef BRU_STATS_EN
    logic [15:0] stat_branches, stat_mispredicts, stat_drops;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic saw_flush;

    branch_resolve_unit_if #(.PC_W(16)) upd_if ();

    branch_resolve_unit #(.PC_W(16), .QDEPTH(4), .CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .data_stall     (data_stall),
        .res_valid      (res_valid),
        .res_is_ctrl    (res_is_ctrl),
        .res_is_cond    (res_is_cond),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .upd            (upd_if.master),
        .q_count        (q_count)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
        .stat_drops       (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch for one cycle, then walk it into EX/MEM (3 posedges total).
    task automatic launch(input logic [15:0] pc, input logic pt, input logic [15:0] ptgt);
        if_valid = 1'b1; if_pc = pc; if_pred_taken = pt; if_pred_target = ptgt;
        tick();
        if_valid = 1'b0; if_pred_taken = 1'b0;
        tick();
        tick();
    endtask

    task automatic resolve(input logic ctrl, input logic cond, input logic tkn, input logic [15:0] tgt);
        res_valid = 1'b1; res_is_ctrl = ctrl; res_is_cond = cond; res_taken = tkn; res_target = tgt;
        #1;
    endtask

    task automatic res_clear();
        res_valid = 1'b0; res_is_ctrl = 1'b0; res_is_cond = 1'b0; res_taken = 1'b0; res_target = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        if_valid = 0; if_pc = '0; if_pred_taken = 0; if_pred_target = '0; data_stall = 0;
        res_clear();
        upd_if.upd_ready = 1'b0;
        #2;
        chk("rst_flush", flush, 0);
        chk("rst_upd_valid", upd_if.upd_valid, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_redirect", redirect_pc, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Correctly predicted taken branch
        launch(16'h0010, 1'b1, 16'h0040);
        resolve(1, 1, 1, 16'h0040);
        chk("ok_taken_flush", flush, 0);
        tick(); res_clear();
        chk("ok_taken_valid", upd_if.upd_valid, 1);
        chk("ok_taken_pc", upd_if.upd_pc, 16'h0010);
        chk("ok_taken_tgt", upd_if.upd_target, 16'h0040);
        chk("ok_taken_tkn", upd_if.upd_taken, 1);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;
        chk("ok_taken_drained", q_count, 0);

        // Direction miss with predicted-taken wrong-path instructions behind it
        if_valid = 1; if_pc = 16'h0020; if_pred_taken = 0; if_pred_target = 16'h0000; tick();
        if_pc = 16'h0021; if_pred_taken = 1; if_pred_target = 16'h0099; tick();
        if_pc = 16'h0022; tick();
        if_pc = 16'h0023;
        resolve(1, 1, 1, 16'h0005);
        chk("dir_miss_flush", flush, 1);
        chk("dir_miss_redirect", redirect_pc, 16'h0005);
        tick();
        if_valid = 0; if_pred_taken = 0;
        // Wrong-path entries would alias-flush if they survived.
        resolve(0, 0, 0, 16'h0000);
        saw_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (flush) saw_flush = 1'b1;
            tick();
        end
        res_clear();
        chk("dir_miss_killed", saw_flush, 0);
        chk("dir_miss_qcount", q_count, 1);
        chk("dir_miss_upd_pc", upd_if.upd_pc, 16'h0020);
        chk("dir_miss_upd_tgt", upd_if.upd_target, 16'h0005);
        chk("dir_miss_upd_tkn", upd_if.upd_taken, 1);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;

        // PC wrap on a not-taken redirect
        launch(16'hFFFF, 1'b1, 16'h1234);
        resolve(1, 1, 0, 16'h1234);
        chk("wrap_flush", flush, 1);
        chk("wrap_redirect", redirect_pc, 16'h0000);
        tick(); res_clear();
        chk("wrap_upd_tgt", upd_if.upd_target, 16'h1234);
        chk("wrap_upd_tkn", upd_if.upd_taken, 0);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;

        // Target miss on a correctly predicted direction
        launch(16'h0050, 1'b1, 16'h0040);
        resolve(1, 0, 1, 16'h0044);
        chk("tgt_miss_flush", flush, 1);
        chk("tgt_miss_redirect", redirect_pc, 16'h0044);
        tick(); res_clear();
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;

        // BTB alias on a non-control instruction
        launch(16'h0030, 1'b1, 16'h0050);
        resolve(0, 0, 0, 16'h0000);
        chk("alias_flush", flush, 1);
        chk("alias_redirect", redirect_pc, 16'h0031);
        tick(); res_clear();
        chk("alias_upd_pc", upd_if.upd_pc, 16'h0030);
        chk("alias_upd_tgt", upd_if.upd_target, 16'h0000);
        chk("alias_upd_tkn", upd_if.upd_taken, 0);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;

        // One-cycle load-use stall behind a predicted branch
        if_valid = 1; if_pc = 16'h0060; if_pred_taken = 1; if_pred_target = 16'h0070; tick();
        if_valid = 0; if_pred_taken = 0; data_stall = 1; tick();
        data_stall = 0; tick();
        resolve(1, 1, 0, 16'h0070);
        chk("stall_bubble_flush", flush, 0);
        tick();
        chk("stall_bubble_nopush", q_count, 0);
        resolve(1, 1, 1, 16'h0070);
        chk("stall_late_flush", flush, 0);
        tick(); res_clear();
        chk("stall_late_qcount", q_count, 1);
        chk("stall_late_upd_pc", upd_if.upd_pc, 16'h0060);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;

        // Five back-to-back branches into a 4-deep queue with no drain
        saw_flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if_valid = (k < 5); if_pc = 16'h0100 + 16'(k);
            if_pred_taken = 1; if_pred_target = 16'h0200;
            if (k >= 3) resolve(1, 1, 1, 16'h0200);
            else begin res_clear(); #1; end
            if (flush) saw_flush = 1'b1;
            tick();
        end
        if_valid = 0; if_pred_taken = 0; res_clear();
        chk("full_no_flush", saw_flush, 0);
        chk("full_qcount", q_count, 4);
        chk("full_head_pc", upd_if.upd_pc, 16'h0100);
`ifdef BRU_STATS_EN
        chk("full_stat_drops", stat_drops, 1);
`endif
        // Push and pop together while full
        launch(16'h0300, 1'b1, 16'h0200);
        upd_if.upd_ready = 1'b1;
        resolve(1, 1, 1, 16'h0200);
        tick(); res_clear(); upd_if.upd_ready = 1'b0; #1;
        chk("full_pushpop_qcount", q_count, 4);
        chk("full_pushpop_head", upd_if.upd_pc, 16'h0101);
        upd_if.upd_ready = 1'b1; tick(); upd_if.upd_ready = 1'b0;
        chk("drain_qcount", q_count, 3);
        chk("drain_head", upd_if.upd_pc, 16'h0102);

        // Asynchronous reset mid-traffic with 3 queued and a mispredict in EX/MEM
        launch(16'h0400, 1'b1, 16'h0010);
        resolve(0, 0, 0, 16'h0000);
        chk("pre_rst_flush", flush, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_upd_valid", upd_if.upd_valid, 0);
        chk("mid_rst_qcount", q_count, 0);
        chk("mid_rst_flush", flush, 0);
        res_clear();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_qcount", q_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
